// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Holds the PC/instruction widths and the buffered fetch entry.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush input.
// Push while full is accepted only when a pop frees a slot the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // pointer and occupancy tracking, flush empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch front-end: sequential request generator, response buffer, redirect flush.
// Optional FETCH_BUFFER_BYPASS_EN forwards a response straight out when the FIFO is empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req_valid,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic              run;
    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   resp_pc;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     count;
    logic [CW:0]       credit;
    logic              full;
    logic              empty;
    logic              req_fire;
    logic              resp_fire;
    logic              keep;
    logic              push_want;
    logic              push;
    logic              pop;
    fetch_entry_t      head;
    fetch_entry_t      resp_entry;
    fetch_entry_t      sel;

    // credits cover both buffered and outstanding words so a push never overflows
    assign credit         = {1'b0, in_flight} + {1'b0, count};
    assign imem_req_valid = run && !redirect_valid && (credit < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // responses with nothing outstanding are stale from before a reset
    assign resp_fire  = imem_resp_valid && (in_flight != '0);
    assign keep       = resp_fire && (discard == '0) && !redirect_valid;
    assign resp_entry = '{pc: resp_pc, instr: imem_resp_data};

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass;

    // forward the arriving word when nothing is queued ahead of it
    always_comb begin
        bypass    = keep && empty;
        out_valid = !redirect_valid && (!empty || bypass);
        sel       = empty ? resp_entry : head;
        push_want = keep && !(bypass && out_ready);
    end
`else
    // output strictly from storage
    always_comb begin
        out_valid = !redirect_valid && !empty;
        sel       = head;
        push_want = keep;
    end
`endif

    assign pop       = out_valid && out_ready && !empty;
    assign push      = push_want && (!full || pop);
    assign out_pc    = out_valid ? sel.pc : '0;
    assign out_instr = out_valid ? sel.instr : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (push),
        .din   (resp_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // hold off requests until the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // outstanding request count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_flight <= '0;
        else        in_flight <= in_flight + CW'(req_fire) - CW'(resp_fire);
    end

    // fetch/response PCs and stale-response drop count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            discard  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            discard  <= in_flight - CW'(resp_fire);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (resp_fire) begin
                if (discard != '0) discard <= discard - CW'(1);
                else               resp_pc <= resp_pc + PC_STEP;
            end
        end
    end

endmodule
